// File: rtl/axi_lite_arb_pkg.sv
// Shared types and constants for the two-requester AXI4-lite master arbiter.
// Imported by the arbiter core and its round-robin grant unit.
package axi_lite_arb_pkg;

  localparam int N_REQ = 2;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA
  } arb_state_e;

  function automatic logic resp_is_err(input logic [1:0] r);
    return (r == SLVERR) || (r == DECERR);
  endfunction

endpackage

// File: rtl/axi_arb_rr.sv
// Two-way arbiter with a registered last-grant pointer.
// Round-robin on ties unless FIXED_PRIO favours requester 0.
module axi_arb_rr
  import axi_lite_arb_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [N_REQ-1:0] req,
  input  logic             gnt_stb,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_id
);

  logic last;

  always_comb begin
    gnt_id = 1'b0;
    unique case (req)
      2'b10:   gnt_id = 1'b1;
      2'b11:   gnt_id = FIXED_PRIO ? 1'b0 : ~last;
      default: gnt_id = 1'b0;
    endcase
    gnt = (req == '0) ? '0 : (N_REQ'(1) << gnt_id);
  end

  // Pointer starts at 1 so requester 0 takes the first tie.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last <= 1'b1;
    end else if (gnt_stb) begin
      last <= gnt_id;
    end
  end

endmodule

// File: rtl/axi_lite_master_arbiter.sv
// Shares one AXI4-lite master port between the loader and the MMIO path.
// One transaction in flight; responses pulse back to the granted requester.
module axi_lite_master_arbiter
  import axi_lite_arb_pkg::*;
#(
  parameter bit         FIXED_PRIO = 1'b0,
  parameter logic [2:0] AXI_PROT   = 3'b000
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ-1:0]       req_we,
  input  logic [N_REQ-1:0][31:0] req_addr,
  input  logic [N_REQ-1:0][31:0] req_wdata,
  input  logic [N_REQ-1:0][3:0]  req_wstrb,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [31:0]            rsp_rdata,
  output logic [1:0]             rsp_resp,
  output logic                   axi_awvalid,
  input  logic                   axi_awready,
  output logic [31:0]            axi_awaddr,
  output logic [2:0]             axi_awprot,
  output logic                   axi_wvalid,
  input  logic                   axi_wready,
  output logic [31:0]            axi_wdata,
  output logic [3:0]             axi_wstrb,
  input  logic                   axi_bvalid,
  output logic                   axi_bready,
  input  logic [1:0]             axi_bresp,
  output logic                   axi_arvalid,
  input  logic                   axi_arready,
  output logic [31:0]            axi_araddr,
  output logic [2:0]             axi_arprot,
  input  logic                   axi_rvalid,
  output logic                   axi_rready,
  input  logic [31:0]            axi_rdata,
  input  logic [1:0]             axi_rresp
);

  arb_state_e       state;
  logic             gid;
  logic             aw_done;
  logic             w_done;
  logic             aw_fin;
  logic             w_fin;
  logic             gnt_stb;
  logic             gnt_id;
  logic [N_REQ-1:0] gnt;

  assign axi_awprot = AXI_PROT;
  assign axi_arprot = AXI_PROT;

  assign gnt_stb   = (state == IDLE) && (|req_valid);
  assign req_ready = (state == IDLE) ? gnt : '0;

  // A channel is finished once its handshake has happened, this cycle or earlier.
  assign aw_fin = aw_done || (axi_awvalid && axi_awready);
  assign w_fin  = w_done  || (axi_wvalid  && axi_wready);

  axi_arb_rr #(
    .FIXED_PRIO(FIXED_PRIO)
  ) u_arb (
    .clk    (clk),
    .rstn   (rstn),
    .req    (req_valid),
    .gnt_stb(gnt_stb),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      gid         <= 1'b0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      rsp_valid   <= '0;
      rsp_rdata   <= '0;
      rsp_resp    <= OKAY;
      axi_awvalid <= 1'b0;
      axi_awaddr  <= '0;
      axi_wvalid  <= 1'b0;
      axi_wdata   <= '0;
      axi_wstrb   <= '0;
      axi_bready  <= 1'b0;
      axi_arvalid <= 1'b0;
      axi_araddr  <= '0;
      axi_rready  <= 1'b0;
    end else begin
      rsp_valid <= '0;
      unique case (state)
        IDLE: begin
          if (gnt_stb) begin
            gid <= gnt_id;
            if (req_we[gnt_id]) begin
              axi_awaddr  <= req_addr[gnt_id];
              axi_wdata   <= req_wdata[gnt_id];
              axi_wstrb   <= req_wstrb[gnt_id];
              axi_awvalid <= 1'b1;
              axi_wvalid  <= 1'b1;
              aw_done     <= 1'b0;
              w_done      <= 1'b0;
              state       <= WR_ADDR_DATA;
            end else begin
              axi_araddr  <= req_addr[gnt_id];
              axi_arvalid <= 1'b1;
              state       <= RD_ADDR;
            end
          end
        end
        WR_ADDR_DATA: begin
          if (axi_awvalid && axi_awready) begin
            axi_awvalid <= 1'b0;
            aw_done     <= 1'b1;
          end
          if (axi_wvalid && axi_wready) begin
            axi_wvalid <= 1'b0;
            w_done     <= 1'b1;
          end
          if (aw_fin && w_fin) begin
            axi_bready <= 1'b1;
            state      <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (axi_bvalid) begin
            axi_bready     <= 1'b0;
            rsp_resp       <= axi_bresp;
            rsp_valid[gid] <= 1'b1;
            state          <= IDLE;
          end
        end
        RD_ADDR: begin
          if (axi_arready) begin
            axi_arvalid <= 1'b0;
            axi_rready  <= 1'b1;
            state       <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (axi_rvalid) begin
            axi_rready     <= 1'b0;
            rsp_rdata      <= axi_rdata;
            rsp_resp       <= axi_rresp;
            rsp_valid[gid] <= 1'b1;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_master_arbiter.sv
// Directed bench for axi_lite_master_arbiter.
// Round-robin instance with scripted slave, plus a fixed-priority instance.
module tb_axi_lite_master_arbiter;
  import axi_lite_arb_pkg::*;

  logic clk;
  logic rstn;

  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0]       req_we;
  logic [1:0][31:0] req_addr;
  logic [1:0][31:0] req_wdata;
  logic [1:0][3:0]  req_wstrb;
  logic [1:0]       rsp_valid;
  logic [31:0]      rsp_rdata;
  logic [1:0]       rsp_resp;
  logic             awvalid, awready, wvalid, wready;
  logic             bvalid, bready, arvalid, arready;
  logic             rvalid, rready;
  logic [31:0]      awaddr, wdata, araddr, rdata;
  logic [2:0]       awprot, arprot;
  logic [3:0]       wstrb;
  logic [1:0]       bresp, rresp;

  logic             auto;
  logic             m_awready, m_wready, m_bvalid, m_arready, m_rvalid;
  logic [31:0]      t_rdata;
  logic [1:0]       t_rresp, t_bresp;

  logic [1:0]       u1_req_valid, u1_req_ready, u1_rsp_valid;
  logic [1:0][31:0] u1_req_addr;
  logic [31:0]      u1_rsp_rdata, u1_awaddr, u1_wdata, u1_araddr;
  logic [1:0]       u1_rsp_resp;
  logic             u1_awvalid, u1_wvalid, u1_bready, u1_arvalid, u1_rready;
  logic [2:0]       u1_awprot, u1_arprot;
  logic [3:0]       u1_wstrb;

  int checks;
  int failures;

  always_comb begin
    if (auto) begin
      awready = 1'b1;
      wready  = 1'b1;
      arready = 1'b1;
      bvalid  = bready;
      rvalid  = rready;
    end else begin
      awready = m_awready;
      wready  = m_wready;
      arready = m_arready;
      bvalid  = m_bvalid;
      rvalid  = m_rvalid;
    end
  end
  assign rdata = t_rdata;
  assign rresp = t_rresp;
  assign bresp = t_bresp;

  axi_lite_master_arbiter #(
    .FIXED_PRIO(1'b0),
    .AXI_PROT  (3'b000)
  ) u0 (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .axi_awvalid(awvalid), .axi_awready(awready),
    .axi_awaddr(awaddr), .axi_awprot(awprot),
    .axi_wvalid(wvalid), .axi_wready(wready),
    .axi_wdata(wdata), .axi_wstrb(wstrb),
    .axi_bvalid(bvalid), .axi_bready(bready), .axi_bresp(bresp),
    .axi_arvalid(arvalid), .axi_arready(arready),
    .axi_araddr(araddr), .axi_arprot(arprot),
    .axi_rvalid(rvalid), .axi_rready(rready),
    .axi_rdata(rdata), .axi_rresp(rresp)
  );

  axi_lite_master_arbiter #(
    .FIXED_PRIO(1'b1),
    .AXI_PROT  (3'b000)
  ) u1 (
    .clk(clk), .rstn(rstn),
    .req_valid(u1_req_valid), .req_ready(u1_req_ready),
    .req_we(2'b00), .req_addr(u1_req_addr),
    .req_wdata('0), .req_wstrb('0),
    .rsp_valid(u1_rsp_valid), .rsp_rdata(u1_rsp_rdata),
    .rsp_resp(u1_rsp_resp),
    .axi_awvalid(u1_awvalid), .axi_awready(1'b1),
    .axi_awaddr(u1_awaddr), .axi_awprot(u1_awprot),
    .axi_wvalid(u1_wvalid), .axi_wready(1'b1),
    .axi_wdata(u1_wdata), .axi_wstrb(u1_wstrb),
    .axi_bvalid(u1_bready), .axi_bready(u1_bready), .axi_bresp(2'b00),
    .axi_arvalid(u1_arvalid), .axi_arready(1'b1),
    .axi_araddr(u1_araddr), .axi_arprot(u1_arprot),
    .axi_rvalid(u1_rready), .axi_rready(u1_rready),
    .axi_rdata(32'h1234), .axi_rresp(2'b00)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int          rem[2];
  int          exp_g[4];
  int          g;

  initial begin
    checks       = 0;
    failures     = 0;
    rstn         = 1'b0;
    auto         = 1'b1;
    m_awready    = 1'b0;
    m_wready     = 1'b0;
    m_bvalid     = 1'b0;
    m_arready    = 1'b0;
    m_rvalid     = 1'b0;
    t_rdata      = '0;
    t_rresp      = OKAY;
    t_bresp      = OKAY;
    req_valid    = '0;
    req_we       = '0;
    req_addr     = '0;
    req_wdata    = '0;
    req_wstrb    = '0;
    u1_req_valid = '0;
    u1_req_addr  = '0;

    // reset values
    #2;
    chk("rst_arvalid", {awvalid, wvalid, arvalid, bready, rready}, 5'b0);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_addr", {awaddr, araddr}, 64'h0);
    chk("rst_prot", {awprot, arprot}, 6'b0);
    chk("rst_rsp", {rsp_rdata, rsp_resp}, 34'h0);
    tick();
    rstn = 1'b1;
    tick();

    // simultaneous reads, round-robin
    rem[0] = 2; rem[1] = 2;
    exp_g  = '{0, 1, 0, 1};
    req_addr[0] = 32'h0;
    req_addr[1] = 32'h8;
    for (int i = 0; i < 4; i++) begin
      req_valid = {rem[1] > 0, rem[0] > 0};
      #1;
      chk("rr_gnt", req_ready, 64'(2'b01 << exp_g[i]));
      g = exp_g[i];
      tick();
      rem[g]--;
      req_valid[g] = 1'b0;
      chk("rr_araddr", araddr, (g == 1) ? 32'h8 : 32'h0);
      tick();
      tick();
      chk("rr_rsp", rsp_valid, 64'(2'b01 << g));
    end
    req_valid = '0;
    tick();

    // fixed priority starves requester 1
    u1_req_valid   = 2'b11;
    u1_req_addr[0] = 32'h0;
    u1_req_addr[1] = 32'h8;
    #1;
    chk("fp_gnt0", u1_req_ready, 2'b01);
    tick();
    tick();
    tick();
    chk("fp_rsp0", u1_rsp_valid, 2'b01);
    chk("fp_gnt1", u1_req_ready, 2'b01);
    tick();
    u1_req_valid = '0;

    // single read, zero wait, then back-to-back SLVERR read
    req_valid   = 2'b01;
    req_we      = 2'b00;
    req_addr[0] = 32'h8;
    t_rdata     = 32'h1;
    t_rresp     = OKAY;
    #1;
    chk("rd_ready", req_ready, 2'b01);
    tick();
    req_valid = '0;
    chk("rd_arvalid", arvalid, 1'b1);
    chk("rd_araddr", araddr, 32'h8);
    chk("rd_rsp_c1", rsp_valid, 2'b00);
    tick();
    chk("rd_rready", {arvalid, rready}, 2'b01);
    chk("rd_rsp_c2", rsp_valid, 2'b00);
    tick();
    chk("rd_rsp_c3", rsp_valid, 2'b01);
    chk("rd_rdata", rsp_rdata, 32'h1);
    chk("rd_resp", rsp_resp, OKAY);
    req_valid   = 2'b01;
    req_addr[0] = 32'h4;
    t_rdata     = 32'hDEAD;
    t_rresp     = SLVERR;
    #1;
    chk("b2b_ready", req_ready, 2'b01);
    tick();
    req_valid = '0;
    tick();
    tick();
    chk("err_rsp", rsp_valid, 2'b01);
    chk("err_rdata", rsp_rdata, 32'hDEAD);
    chk("err_resp", rsp_resp, 2'b10);
    tick();
    chk("err_idle", u0.state, IDLE);
    chk("err_hold", {rsp_valid, rsp_rdata}, {2'b00, 32'hDEAD});

    // skewed write handshakes
    auto         = 1'b0;
    req_valid    = 2'b10;
    req_we       = 2'b10;
    req_addr[1]  = 32'h4;
    req_wdata[1] = 32'hA5;
    req_wstrb[1] = 4'hF;
    t_bresp      = OKAY;
    #1;
    chk("wr_ready", req_ready, 2'b10);
    tick();
    req_valid = '0;
    m_awready = 1'b1;
    chk("wr_c1_valids", {awvalid, wvalid}, 2'b11);
    chk("wr_c1_fields", {awaddr, wdata, wstrb}, {32'h4, 32'hA5, 4'hF});
    tick();
    m_awready = 1'b0;
    chk("wr_c2", {awvalid, wvalid, bready}, 3'b010);
    tick();
    chk("wr_c3", {awvalid, wvalid, bready}, 3'b010);
    tick();
    m_wready = 1'b1;
    chk("wr_c4", {awvalid, wvalid, bready}, 3'b010);
    tick();
    m_wready = 1'b0;
    m_bvalid = 1'b1;
    chk("wr_c5", {awvalid, wvalid, bready}, 3'b001);
    tick();
    m_bvalid = 1'b0;
    chk("wr_rsp", rsp_valid, 2'b10);
    chk("wr_resp", rsp_resp, OKAY);
    tick();

    // reset in RD_DATA with rvalid low
    m_arready   = 1'b1;
    m_rvalid    = 1'b0;
    req_valid   = 2'b01;
    req_we      = 2'b00;
    req_addr[0] = 32'h10;
    tick();
    req_valid = '0;
    tick();
    chk("mid_rready", rready, 1'b1);
    rstn = 1'b0;
    #1;
    chk("mid_valids", {awvalid, wvalid, arvalid, bready, rready}, 5'b0);
    chk("mid_regs", {araddr, rsp_rdata, rsp_resp}, 66'h0);
    chk("mid_prot", {awprot, arprot}, 6'b0);
    tick();
    rstn = 1'b1;
    tick();
    chk("mid_norsp1", rsp_valid, 2'b00);
    tick();
    chk("mid_norsp2", rsp_valid, 2'b00);

    // next request completes normally
    auto        = 1'b1;
    req_valid   = 2'b10;
    req_we      = 2'b00;
    req_addr[1] = 32'hC;
    t_rdata     = 32'h55;
    t_rresp     = OKAY;
    #1;
    chk("post_ready", req_ready, 2'b10);
    tick();
    req_valid = '0;
    tick();
    tick();
    chk("post_rsp", rsp_valid, 2'b10);
    chk("post_rdata", rsp_rdata, 32'h55);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
